// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - multi-cycle one-bit-per-clock shifter (SRA/SRL/SLL/ROL) with valid/ready handshakes
module iter_shift_unit #(
    parameter int WIDTH = 4,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;
    logic [WIDTH-1:0] w_step;
    logic             w_accept;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_valid;
    assign out_data  = r_out;
    assign w_accept  = in_valid && in_ready;

    // One-bit step of the working operand for the latched operation
    always_comb begin
        w_step = r_data;
        case (r_op)
            OP_SRA:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            OP_SRL:  w_step = {1'b0, r_data[WIDTH-1:1]};
            OP_SLL:  w_step = {r_data[WIDTH-2:0], 1'b0};
            OP_ROL:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            default: w_step = r_data;
        endcase
    end

    // Next-state logic; DONE holds until the registered result has been taken
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (in_amt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_valid && out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand capture, stepping, and result register; the first DONE cycle loads
    // the result so out_valid rises amt+1 cycles after the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        r_cnt  <= in_amt;
                        r_op   <= in_op;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt - SHW'(1);
                end
                S_DONE: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_out   <= r_data;
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// tb/tb_iter_shift_unit.sv - scoreboard bench for iter_shift_unit
module tb_iter_shift_unit;

    localparam int WIDTH = 4;
    localparam int SHW   = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    logic             ready_dir;
    logic             ready_rnd;
    logic             stall_mode;

    int               n_asrt;
    int               n_fail;
    int               n_results;
    logic [WIDTH-1:0] exp_q[$];

    assign out_ready = stall_mode ? ready_rnd : ready_dir;

    iter_shift_unit #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Random consumer stalls, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        ready_rnd = 1'($urandom_range(0, 1));
    end

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] d,
                                               input int amt);
        logic [WIDTH-1:0] v;
        v = d;
        for (int k = 0; k < amt; k++) begin
            case (op)
                2'b00: v = {v[WIDTH-1], v[WIDTH-1:1]};
                2'b01: v = {1'b0, v[WIDTH-1:1]};
                2'b10: v = {v[WIDTH-2:0], 1'b0};
                default: v = {v[WIDTH-2:0], v[WIDTH-1]};
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_timeout", 32'(t < 200), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        exp_q.push_back(model(op, d, int'(amt)));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: compare each result on the cycle it is handed off
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_results++;
            n_asrt++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_result observed=%0h expected=none", out_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                assert (out_data === e) else begin
                    n_fail++;
                    $error("FAIL result observed=%0h expected=%0h", out_data, e);
                end
            end
        end
    end

    initial begin
        n_asrt     = 0;
        n_fail     = 0;
        n_results  = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_amt     = '0;
        in_op      = '0;
        ready_dir  = 1'b1;
        stall_mode = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // SRA 1000 by 3: valid exactly at the 4th edge after accept, one cycle
        send(2'b00, 4'b1000, 2'd3);
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            chk("sra3_valid_timing", 32'(out_valid), 32'(i == 4));
            if (i == 4) chk("sra3_data", 32'(out_data), 32'b1111);
        end
        @(posedge clk); #1;

        // Assorted directed operations
        send(2'b01, 4'b1000, 2'd2);
        send(2'b10, 4'b0111, 2'd1);
        send(2'b11, 4'b1001, 2'd1);
        drain();
        chk("last_rol_data", 32'(out_data), 32'b0011);

        // Reset while shifting drops the command
        in_valid = 1'b1; in_op = 2'b10; in_data = 4'b0001; in_amt = 2'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midshift_busy", 32'(busy), 32'd1);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero amount: result one cycle after accept
        send(2'b00, 4'b1010, 2'd0);
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            chk("amt0_valid_timing", 32'(out_valid), 32'(i == 1));
            if (i == 1) chk("amt0_data", 32'(out_data), 32'b1010);
        end
        @(posedge clk); #1;

        // Held result under back-pressure; in_valid while busy is ignored
        ready_dir = 1'b0;
        send(2'b10, 4'b0011, 2'd2);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            chk("stall_valid_timeout", 32'(t < 20), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", 32'(out_data), 32'b1100);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            in_valid = (i == 1);
            in_op = 2'b00; in_data = 4'b0101; in_amt = 2'd1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        ready_dir = 1'b1;
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("idle_no_extra_valid", 32'(out_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_keeps_data", 32'(out_data), 32'b1100);

        // Random commands with random consumer stalls
        stall_mode = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        drain();
        stall_mode = 1'b0;
        @(posedge clk); #1;
        chk("result_count", 32'(n_results), 32'd1006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
